// File: rtl/hal_dsp_dot_seq_pkg.sv
// ---------------------------------------------------------------------------
// hal_dsp_dot_seq_pkg
//   Shared types for the dot-product sequencer that drives an fmac32 DSP
//   primitive.
//     seq_state_t : sequencer phase (IDLE, ACCUM, DRAIN, HOLD)
//     FP32_ZERO   : reset value of the result register
//     seq_token_t : tag-pipe token {last, count}. The count field is sized
//                   by TOK_CNT_W, the widest element counter supported; the
//                   sequencer zero-extends its CNT_W-bit count into it.
// ---------------------------------------------------------------------------
package hal_dsp_dot_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DRAIN = 2'd2,
        HOLD  = 2'd3
    } seq_state_t;

    localparam logic [31:0] FP32_ZERO = 32'h0000_0000;

    localparam int TOK_CNT_W = 32;

    typedef struct packed {
        logic                 last;
        logic [TOK_CNT_W-1:0] count;
    } seq_token_t;

endpackage

// File: rtl/hal_dsp_dot_seq_tag_pipe.sv
// ---------------------------------------------------------------------------
// hal_dsp_dot_seq_tag_pipe
//   LATENCY-deep shift register that travels alongside the DSP pipeline.
//   A token pushed in cycle t is presented on the exit port in cycle
//   t+LATENCY, the same cycle the DSP presents the matching result.
//
//   clk         in   clock
//   rst_n       in   asynchronous active-low reset, clears every stage
//   push_i      in   push tok_i this cycle
//   tok_i       in   token {last, count}
//   exit_vld_o  out  a token occupies the exit stage
//   exit_tok_o  out  token in the exit stage
//   any_vld_o   out  any stage holds a token
//   last_vld_o  out  any stage holds a token with last set
// ---------------------------------------------------------------------------
module hal_dsp_dot_seq_tag_pipe
    import hal_dsp_dot_seq_pkg::*;
#(
    parameter int LATENCY = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push_i,
    input  seq_token_t tok_i,
    output logic       exit_vld_o,
    output seq_token_t exit_tok_o,
    output logic       any_vld_o,
    output logic       last_vld_o
);

    logic [LATENCY-1:0] vld_q;
    seq_token_t         tok_q [LATENCY];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                tok_q[i] <= '0;
            end
        end else begin
            vld_q[0] <= push_i;
            tok_q[0] <= push_i ? tok_i : '0;
            for (int i = 1; i < LATENCY; i++) begin
                vld_q[i] <= vld_q[i-1];
                tok_q[i] <= tok_q[i-1];
            end
        end
    end

    always_comb begin
        last_vld_o = 1'b0;
        for (int i = 0; i < LATENCY; i++) begin
            if (vld_q[i] && tok_q[i].last) begin
                last_vld_o = 1'b1;
            end
        end
    end

    assign exit_vld_o = vld_q[LATENCY-1];
    assign exit_tok_o = tok_q[LATENCY-1];
    assign any_vld_o  = |vld_q;

endmodule

// File: rtl/hal_dsp_dot_product_sequencer.sv
// ---------------------------------------------------------------------------
// hal_dsp_dot_product_sequencer
//   Initiator for an fmac32 DSP instance. Accepts a stream of FP32 (x,y)
//   pairs framed by in_last, drives the DSP op port (accumulate cleared on
//   the first element of each vector), follows the DSP latency with a tag
//   pipe and captures each finished dot product into a one-entry result
//   register with valid/ready.
//
//   Optional feature macro: HAL_DSP_DOT_SEQ_OVERLAP_EN
//     undefined : one vector at a time (IDLE/ACCUM/DRAIN/HOLD sequencing)
//     defined   : the next vector may stream in while the previous result
//                 is in flight; only last beats stall.
//
//   Parameters
//     LATENCY  DSP result latency in cycles (>= 1), must match the fmac32
//     CNT_W    element counter width, counter saturates at all-ones
//
//   Ports
//     clk, rst_n                       clock, async active-low reset
//     in_valid/in_ready                element beat handshake
//     in_x, in_y, in_last              FP32 operands, end-of-vector marker
//     dsp_x_out, dsp_y_out             operand pass-through to the DSP
//     dsp_accumulate_out               0 on the first beat of a vector
//     dsp_valid_out                    DSP op strobe (accepted beat)
//     dsp_result_in                    DSP result
//     res_valid/res_ready              result handshake
//     res_data, res_count              dot product and element count
//     busy                             activity or tokens in flight
//
// state | meaning
// ------+----------------------------------------------------------------
// IDLE  | waiting for the first beat of a vector
// ACCUM | mid-vector, accepting further beats
// DRAIN | last beat taken, waiting for its token to leave the tag pipe
// HOLD  | result valid, waiting for res_ready
// ---------------------------------------------------------------------------
module hal_dsp_dot_product_sequencer
    import hal_dsp_dot_seq_pkg::*;
#(
    parameter int LATENCY = 4,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_x,
    input  logic [31:0]      in_y,
    input  logic             in_last,
    output logic [31:0]      dsp_x_out,
    output logic [31:0]      dsp_y_out,
    output logic             dsp_accumulate_out,
    output logic             dsp_valid_out,
    input  logic [31:0]      dsp_result_in,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [31:0]      res_data,
    output logic [CNT_W-1:0] res_count,
    output logic             busy
);

    if (LATENCY < 1) begin : g_bad_latency
        $fatal(1, "hal_dsp_dot_product_sequencer: LATENCY must be >= 1");
    end
    if ((CNT_W < 1) || (CNT_W > TOK_CNT_W)) begin : g_bad_cnt_w
        $fatal(1, "hal_dsp_dot_product_sequencer: CNT_W out of range");
    end

    logic             accept;
    logic             first_q, first_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             res_valid_q, res_valid_d;
    logic [31:0]      res_data_q, res_data_d;
    logic [CNT_W-1:0] res_count_q, res_count_d;

    seq_token_t       push_tok;
    seq_token_t       exit_tok;
    logic             exit_vld;
    logic             tok_any_vld;
    logic             tok_last_vld;
    logic             capture;

    assign accept = in_valid && in_ready;

    // first_q marks the vector boundary: the next accepted beat starts a new
    // vector, so the DSP must overwrite rather than accumulate.
    always_comb begin
        first_d = first_q;
        count_d = count_q;
        if (accept) begin
            first_d = in_last;
            if (first_q) begin
                count_d = CNT_W'(1);
            end else if (count_q != {CNT_W{1'b1}}) begin
                count_d = count_q + 1'b1;
            end
        end
    end

    always_comb begin
        push_tok       = '0;
        push_tok.last  = in_last;
        push_tok.count = TOK_CNT_W'(count_d);
    end

    hal_dsp_dot_seq_tag_pipe #(
        .LATENCY (LATENCY)
    ) u_tag_pipe (
        .clk        (clk),
        .rst_n      (rst_n),
        .push_i     (accept),
        .tok_i      (push_tok),
        .exit_vld_o (exit_vld),
        .exit_tok_o (exit_tok),
        .any_vld_o  (tok_any_vld),
        .last_vld_o (tok_last_vld)
    );

    if (CNT_W < TOK_CNT_W) begin : g_cnt_hi
        logic unused_cnt_hi;
        assign unused_cnt_hi = ^exit_tok.count[TOK_CNT_W-1:CNT_W];
    end

    // Only the token of a last beat carries a finished dot product.
    assign capture = exit_vld && exit_tok.last;

    // Capture wins over a same-cycle handshake so a fresh result is never lost.
    always_comb begin
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        res_count_d = res_count_q;
        if (res_valid_q && res_ready) begin
            res_valid_d = 1'b0;
        end
        if (capture) begin
            res_valid_d = 1'b1;
            res_data_d  = dsp_result_in;
            res_count_d = exit_tok.count[CNT_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            first_q     <= 1'b1;
            count_q     <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= FP32_ZERO;
            res_count_q <= '0;
        end else begin
            first_q     <= first_d;
            count_q     <= count_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_count_q <= res_count_d;
        end
    end

`ifdef HAL_DSP_DOT_SEQ_OVERLAP_EN
    // Phase is !first_q, the pending last is any last token in the tag pipe.
    // Non-last beats always flow; a last beat waits until the previous
    // result has both left the pipe and been (or is being) consumed.
    always_comb begin
        in_ready = !in_last || !(tok_last_vld || (res_valid_q && !res_ready));
    end

    assign busy = !first_q || tok_any_vld || res_valid_q;
`else
    seq_state_t state_q, state_d;

    logic unused_last_vld;
    assign unused_last_vld = tok_last_vld;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        in_ready = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_d = in_last ? DRAIN : ACCUM;
                end
            end
            ACCUM: begin
                in_ready = 1'b1;
                if (in_valid && in_last) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (capture) begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (res_valid_q && res_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy = (state_q != IDLE) || tok_any_vld;
`endif

    assign dsp_x_out          = in_x;
    assign dsp_y_out          = in_y;
    assign dsp_accumulate_out = !first_q;
    assign dsp_valid_out      = accept;
    assign res_valid          = res_valid_q;
    assign res_data           = res_data_q;
    assign res_count          = res_count_q;

endmodule

// File: tb/tb_hal_dsp_dot_product_sequencer.sv
module tb_hal_dsp_dot_product_sequencer;

    localparam int LAT = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        in_valid, in_last;
    logic [31:0] in_x, in_y;
    logic        rr_fixed, rr_rand, rr_mode;
    logic        res_ready;
    assign res_ready = rr_mode ? rr_rand : rr_fixed;

    always @(posedge clk) begin
        #2 rr_rand = 1'($urandom_range(0, 1));
    end

    // DUT A: CNT_W=16, DUT B: CNT_W=2; both see the same input stream.
    logic        in_ready_a, acc_a, dval_a, res_valid_a, busy_a;
    logic [31:0] dsp_x_a, dsp_y_a, dsp_res_a, res_data_a;
    logic [15:0] res_count_a;
    logic        in_ready_b, acc_b, dval_b, res_valid_b, busy_b;
    logic [31:0] dsp_x_b, dsp_y_b, dsp_res_b, res_data_b;
    logic [1:0]  res_count_b;

    hal_dsp_dot_product_sequencer #(.LATENCY(LAT), .CNT_W(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_a),
        .in_x(in_x), .in_y(in_y), .in_last(in_last),
        .dsp_x_out(dsp_x_a), .dsp_y_out(dsp_y_a), .dsp_accumulate_out(acc_a),
        .dsp_valid_out(dval_a), .dsp_result_in(dsp_res_a),
        .res_valid(res_valid_a), .res_ready(res_ready), .res_data(res_data_a),
        .res_count(res_count_a), .busy(busy_a));

    hal_dsp_dot_product_sequencer #(.LATENCY(LAT), .CNT_W(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_b),
        .in_x(in_x), .in_y(in_y), .in_last(in_last),
        .dsp_x_out(dsp_x_b), .dsp_y_out(dsp_y_b), .dsp_accumulate_out(acc_b),
        .dsp_valid_out(dval_b), .dsp_result_in(dsp_res_b),
        .res_valid(res_valid_b), .res_ready(res_ready), .res_data(res_data_b),
        .res_count(res_count_b), .busy(busy_b));

    // FP32 helpers restricted to non-negative integers below 2**24.
    function automatic int fp_to_int(input logic [31:0] f);
        int e;
        int m;
        if (f[30:0] == 31'd0) return 0;
        e = int'(f[30:23]) - 127;
        m = int'({1'b1, f[22:0]});
        if (e >= 23) return m << (e - 23);
        return m >> (23 - e);
    endfunction

    function automatic logic [31:0] int_to_fp(input int v);
        int p;
        logic [31:0] fr;
        if (v == 0) return 32'h0;
        p = 0;
        for (int i = 0; i < 31; i++) if (v[i]) p = i;
        fr = (p >= 23) ? 32'(v >> (p - 23)) : 32'(v << (23 - p));
        return {1'b0, 8'(p + 127), fr[22:0]};
    endfunction

    // Mock fmac32 instances: accumulate register plus LAT-deep result pipe.
    int          macc_a, macc_b;
    logic [31:0] mp_a [LAT];
    logic [31:0] mp_b [LAT];
    always @(posedge clk or negedge rst_n) begin
        int nxt;
        if (!rst_n) begin
            macc_a <= 0;
            for (int i = 0; i < LAT; i++) mp_a[i] <= 32'h0;
        end else begin
            for (int i = 1; i < LAT; i++) mp_a[i] <= mp_a[i-1];
            mp_a[0] <= 32'h7FC0_0000;
            if (dval_a) begin
                nxt = (acc_a ? macc_a : 0) + fp_to_int(dsp_x_a) * fp_to_int(dsp_y_a);
                macc_a  <= nxt;
                mp_a[0] <= int_to_fp(nxt);
            end
        end
    end
    always @(posedge clk or negedge rst_n) begin
        int nxt;
        if (!rst_n) begin
            macc_b <= 0;
            for (int i = 0; i < LAT; i++) mp_b[i] <= 32'h0;
        end else begin
            for (int i = 1; i < LAT; i++) mp_b[i] <= mp_b[i-1];
            mp_b[0] <= 32'h7FC0_0000;
            if (dval_b) begin
                nxt = (acc_b ? macc_b : 0) + fp_to_int(dsp_x_b) * fp_to_int(dsp_y_b);
                macc_b  <= nxt;
                mp_b[0] <= int_to_fp(nxt);
            end
        end
    end
    assign dsp_res_a = mp_a[LAT-1];
    assign dsp_res_b = mp_b[LAT-1];

    int errs = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: per-vector integer sum and element count.
    typedef struct {
        logic [31:0] data;
        int          cnt;
    } exp_t;
    exp_t exp_q[$];
    bit   mdl_first = 1'b1;
    int   mdl_sum = 0;
    int   mdl_cnt = 0;

    // Called at posedge+2; returns at posedge+2 after the beat is accepted.
    task automatic beat(input int a, input int b, input bit last, output int w);
        exp_t e;
        in_valid = 1'b1;
        in_x     = int_to_fp(a);
        in_y     = int_to_fp(b);
        in_last  = last;
        w = 0;
        @(negedge clk);
        while (!in_ready_a && w < 300) begin
            @(negedge clk);
            w++;
        end
        if (w >= 300) begin
            chk("beat_wait_timeout", 32'(w), 32'd0);
        end else begin
            chk("in_ready_b_match", {31'd0, in_ready_b}, {31'd0, in_ready_a});
            chk("dsp_accumulate", {31'd0, acc_a}, {31'd0, !mdl_first});
            chk("dsp_valid", {31'd0, dval_a}, 32'd1);
            if (mdl_first) begin
                mdl_sum = 0;
                mdl_cnt = 0;
            end
            mdl_sum += a * b;
            mdl_cnt++;
            mdl_first = last;
            if (last) begin
                e.data = int_to_fp(mdl_sum);
                e.cnt  = mdl_cnt;
                exp_q.push_back(e);
            end
        end
        @(posedge clk);
        #2;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Scoreboard: every result handshake must match the next model entry.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && res_valid_a && res_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_result", res_data_a, 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                chk("sb_data_a", res_data_a, e.data);
                chk("sb_count_a", {16'd0, res_count_a}, 32'(e.cnt));
                chk("sb_valid_b", {31'd0, res_valid_b}, 32'd1);
                chk("sb_data_b", res_data_b, e.data);
                chk("sb_count_b", {30'd0, res_count_b}, 32'((e.cnt > 3) ? 3 : e.cnt));
            end
        end
    end

    typedef struct {
        int          n;
        int          xs [6];
        int          ys [6];
        logic [31:0] exp_data;
        int          cnt_a;
        int          cnt_b;
    } vec_t;
    vec_t tbl [4];

    task automatic run_vec(input int v);
        int k;
        int w;
        for (int i = 0; i < tbl[v].n; i++) begin
            beat(tbl[v].xs[i], tbl[v].ys[i], i == tbl[v].n - 1, w);
        end
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!res_valid_a && k < 30);
        chk("res_latency", 32'(k), 32'(LAT + 1));
        chk("vec_data", res_data_a, tbl[v].exp_data);
        chk("vec_count_a", {16'd0, res_count_a}, 32'(tbl[v].cnt_a));
        chk("vec_count_b", {30'd0, res_count_b}, 32'(tbl[v].cnt_b));
    endtask

    task automatic post_idle();
        @(negedge clk);
        chk("idle_busy", {31'd0, busy_a}, 32'd0);
        chk("idle_res_valid", {31'd0, res_valid_a}, 32'd0);
        @(posedge clk);
        #2;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int w;
        int seen;
        int len;
        bit ok;
        logic [31:0] hold_d;
        int waits [6];

        tbl[0] = '{2, '{1, 2, 0, 0, 0, 0}, '{3, 4, 0, 0, 0, 0}, 32'h4130_0000, 2, 2};
        tbl[1] = '{1, '{2, 0, 0, 0, 0, 0}, '{2, 0, 0, 0, 0, 0}, 32'h4080_0000, 1, 1};
        tbl[2] = '{5, '{1, 1, 1, 1, 1, 0}, '{1, 1, 1, 1, 1, 0}, 32'h40A0_0000, 5, 3};
        tbl[3] = '{3, '{2, 3, 0, 0, 0, 0}, '{5, 1, 7, 0, 0, 0}, 32'h4150_0000, 3, 3};

        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_x     = 32'h0;
        in_y     = 32'h0;
        rr_fixed = 1'b1;
        rr_mode  = 1'b0;

        repeat (3) @(negedge clk);
        chk("rst_res_valid", {31'd0, res_valid_a}, 32'd0);
        chk("rst_res_data", res_data_a, 32'h0);
        chk("rst_res_count", {16'd0, res_count_a}, 32'd0);
        chk("rst_busy", {31'd0, busy_a}, 32'd0);
        chk("rst_accumulate", {31'd0, acc_a}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready_a}, 32'd1);
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #2;

        // Directed table: two-element, single-beat, saturating count.
        for (int v = 0; v < 3; v++) begin
            run_vec(v);
            post_idle();
        end

        // Hold the result with res_ready low, then a fresh vector.
        rr_fixed = 1'b0;
        run_vec(0);
        hold_d  = res_data_a;
        in_last = 1'b1;
        ok = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (res_data_a !== hold_d || !res_valid_a || in_ready_a) ok = 1'b0;
        end
        chk("hold_stable", {31'd0, ok}, 32'd1);
        @(posedge clk);
        #2;
        in_last  = 1'b0;
        rr_fixed = 1'b1;
        @(posedge clk);
        #2;
        run_vec(3);
        post_idle();

        // Reset while draining: in-flight result is discarded.
        beat(1, 3, 1'b0, w);
        beat(2, 4, 1'b1, w);
        @(negedge clk);
        @(negedge clk);
        chk("drain_busy", {31'd0, busy_a}, 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_res_valid", {31'd0, res_valid_a}, 32'd0);
        chk("mid_rst_busy", {31'd0, busy_a}, 32'd0);
        chk("mid_rst_res_data", res_data_a, 32'h0);
        chk("mid_rst_accumulate", {31'd0, acc_a}, 32'd0);
        exp_q.delete();
        mdl_first = 1'b1;
        @(posedge clk);
        #2 rst_n = 1'b1;
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (res_valid_a) seen++;
        end
        chk("no_res_after_rst", 32'(seen), 32'd0);
        @(posedge clk);
        #2;

`ifdef HAL_DSP_DOT_SEQ_OVERLAP_EN
        // Back-to-back vectors: only the second last beat may stall.
        beat(1, 1, 1'b0, waits[0]);
        beat(1, 2, 1'b0, waits[1]);
        beat(1, 3, 1'b1, waits[2]);
        beat(2, 1, 1'b0, waits[3]);
        beat(3, 1, 1'b0, waits[4]);
        beat(4, 1, 1'b1, waits[5]);
        for (int i = 0; i < 5; i++) chk("overlap_no_stall", 32'(waits[i]), 32'd0);
        chk("overlap_last_stall", {31'd0, waits[5] > 0}, 32'd1);
        seen = 0;
        while ((exp_q.size() != 0 || busy_a) && seen < 100) begin
            @(negedge clk);
            seen++;
        end
        chk("overlap_drain", 32'(exp_q.size()), 32'd0);
        @(posedge clk);
        #2;
`else
        waits[0] = 0;
`endif

        // Randomised vectors with random gaps and random res_ready.
        rr_mode = 1'b1;
        for (int v = 0; v < 40; v++) begin
            len = $urandom_range(1, 6);
            for (int i = 0; i < len; i++) begin
                if ($urandom_range(0, 3) == 0) begin
                    @(posedge clk);
                    #2;
                end
                beat($urandom_range(0, 7), $urandom_range(0, 7), i == len - 1, w);
            end
        end
        seen = 0;
        while ((exp_q.size() != 0 || busy_a) && seen < 2000) begin
            @(negedge clk);
            seen++;
        end
        chk("random_drain", 32'(exp_q.size()), 32'd0);
        chk("random_idle", {31'd0, busy_a}, 32'd0);
        rr_mode = 1'b0;

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
